// File: rtl/pq_req_stager_if.sv
// Request-side valid/ready port and PQ issue port of the heap-PQ request stager.
// The stager uses the slave view; the request source / PQ side uses the master view.
interface pq_req_stager_if #(
    parameter int unsigned KW = 8,
    parameter int unsigned VW = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_op;
    logic [KW+VW-1:0]  req_kv;
    logic              pq_enq;
    logic              pq_deq;
    logic [KW+VW-1:0]  pq_kvi;

    modport master (
        output req_valid, req_op, req_kv,
        input  req_ready, pq_enq, pq_deq, pq_kvi
    );

    modport slave (
        input  req_valid, req_op, req_kv,
        output req_ready, pq_enq, pq_deq, pq_kvi
    );
endinterface

// File: rtl/pq_req_stager.sv
// Buffers enq/deq requests for the pipelined heap PQ and issues them with a minimum
// spacing, dropping illegal ops against a tracked occupancy and fusing enq+deq pairs.
module pq_req_stager #(
    parameter int unsigned KEY_WIDTH   = 8,
    parameter int unsigned VAL_WIDTH   = 8,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned PQ_CAPACITY = 15,
    parameter int unsigned ISSUE_GAP   = 4,
    parameter bit          MERGE_EN    = 1'b1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    pq_req_stager_if.slave                     bus,
    output logic [$clog2(PQ_CAPACITY+1)-1:0]   occ,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
    output logic                               err_enq_full,
    output logic                               err_deq_empty
);
    localparam int unsigned KVW = KEY_WIDTH + VAL_WIDTH;
    localparam int unsigned OW  = $clog2(PQ_CAPACITY + 1);
    localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW  = $clog2(FIFO_DEPTH);
    localparam int unsigned GW  = $clog2(ISSUE_GAP + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;
    state_t state, state_nx;

    logic [KVW:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic [OW-1:0]  occ_r;
    logic [GW-1:0]  gap_cnt, gap_nx;

    // Registered issue decision; non-zero only during the ISSUE cycle.
    logic           iss_enq, iss_deq, iss_efull, iss_eempty;
    logic [1:0]     iss_pop;
    logic [KVW-1:0] kvi_r;

    logic           push, load, fuse;
    logic [CW-1:0]  avail;
    logic [OW-1:0]  occ_upd;
    logic [PW-1:0]  head_idx;
    logic [KVW:0]   h0;
    logic           h1_deq;
    logic           d_enq, d_deq, d_efull, d_eempty;
    logic [1:0]     d_pop;

    assign bus.req_ready = rst_n && (count < CW'(FIFO_DEPTH));
    assign push          = bus.req_valid && bus.req_ready;

    always_comb begin
        occ_upd = occ_r;
        if (iss_enq && !iss_deq)
            occ_upd = occ_r + OW'(1);
        else if (iss_deq && !iss_enq)
            occ_upd = occ_r - OW'(1);
    end

    // iss_pop is zero outside ISSUE, so these views cover IDLE/GAP decisions too:
    // during ISSUE the next decision looks past the entries being popped.
    assign avail    = count - CW'(iss_pop);
    assign head_idx = rd_ptr + PW'(iss_pop);
    assign h0       = mem[head_idx];
    assign h1_deq   = mem[head_idx + PW'(1)][KVW];

    always_comb begin
        d_enq    = 1'b0;
        d_deq    = 1'b0;
        d_efull  = 1'b0;
        d_eempty = 1'b0;
        d_pop    = 2'd1;
        fuse     = MERGE_EN && (avail >= CW'(2)) && h1_deq && (occ_upd != '0);
        if (!h0[KVW]) begin
            if (fuse) begin
                d_enq = 1'b1;
                d_deq = 1'b1;
                d_pop = 2'd2;
            end else if (occ_upd < OW'(PQ_CAPACITY)) begin
                d_enq = 1'b1;
            end else begin
                d_efull = 1'b1;
            end
        end else if (occ_upd != '0) begin
            d_deq = 1'b1;
        end else begin
            d_eempty = 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        gap_nx   = gap_cnt;
        load     = 1'b0;
        unique case (state)
            IDLE: begin
                if (avail != '0) begin
                    load     = 1'b1;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                if ((iss_enq || iss_deq) && (ISSUE_GAP > 1)) begin
                    state_nx = GAP;
                    gap_nx   = GW'(ISSUE_GAP - 1);
                end else if (avail != '0) begin
                    load = 1'b1;
                end else begin
                    state_nx = IDLE;
                end
            end
            GAP: begin
                if (gap_cnt > GW'(1)) begin
                    gap_nx = gap_cnt - GW'(1);
                end else begin
                    gap_nx = '0;
                    if (avail != '0) begin
                        load     = 1'b1;
                        state_nx = ISSUE;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {bus.req_op, bus.req_kv};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            occ_r      <= '0;
            gap_cnt    <= '0;
            iss_enq    <= 1'b0;
            iss_deq    <= 1'b0;
            iss_efull  <= 1'b0;
            iss_eempty <= 1'b0;
            iss_pop    <= 2'd0;
            kvi_r      <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            rd_ptr     <= rd_ptr + PW'(iss_pop);
            count      <= count + CW'(push) - CW'(iss_pop);
            occ_r      <= occ_upd;
            gap_cnt    <= gap_nx;
            iss_enq    <= load && d_enq;
            iss_deq    <= load && d_deq;
            iss_efull  <= load && d_efull;
            iss_eempty <= load && d_eempty;
            iss_pop    <= load ? d_pop : 2'd0;
            if (load && d_enq)
                kvi_r <= h0[KVW-1:0];
        end
    end

    assign bus.pq_enq    = rst_n && iss_enq;
    assign bus.pq_deq    = rst_n && iss_deq;
    assign bus.pq_kvi    = rst_n ? kvi_r : '0;
    assign err_enq_full  = rst_n && iss_efull;
    assign err_deq_empty = rst_n && iss_eempty;
    assign occ           = rst_n ? occ_r : '0;
    assign fifo_count    = rst_n ? count : '0;
endmodule

// File: tb/tb_pq_req_stager.sv
// Bench for pq_req_stager: a queue/timestamp model checks the merging instance every cycle;
// directed scenarios add literal timing checks on both the merging and non-merging instances.
module tb_pq_req_stager;
    localparam int unsigned KW    = 8;
    localparam int unsigned VW    = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CAP   = 15;
    localparam int unsigned GAPC  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_op = 1'b0;
    logic [15:0] req_kv = '0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          saw_full = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pq_req_stager_if #(.KW(KW), .VW(VW)) if0 ();
    pq_req_stager_if #(.KW(KW), .VW(VW)) if1 ();
    assign if0.req_valid = req_valid;
    assign if0.req_op    = req_op;
    assign if0.req_kv    = req_kv;
    assign if1.req_valid = req_valid;
    assign if1.req_op    = req_op;
    assign if1.req_kv    = req_kv;

    logic [3:0] occ0, occ1, fc0, fc1;
    logic       ef0, ed0, ef1, ed1;

    pq_req_stager #(.KEY_WIDTH(KW), .VAL_WIDTH(VW), .FIFO_DEPTH(DEPTH), .PQ_CAPACITY(CAP),
                    .ISSUE_GAP(GAPC), .MERGE_EN(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0), .occ(occ0), .fifo_count(fc0),
        .err_enq_full(ef0), .err_deq_empty(ed0));

    pq_req_stager #(.KEY_WIDTH(KW), .VAL_WIDTH(VW), .FIFO_DEPTH(DEPTH), .PQ_CAPACITY(CAP),
                    .ISSUE_GAP(GAPC), .MERGE_EN(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1), .occ(occ1), .fifo_count(fc1),
        .err_enq_full(ef1), .err_deq_empty(ed1));

    typedef struct {logic op; logic [15:0] kv; int acc;} ent_t;
    typedef struct {int c; logic enq; logic deq; logic ef; logic ed; logic [15:0] kv; logic [3:0] occ;} ev_t;

    ent_t mq[$];
    ev_t  log0[$];
    ev_t  log1[$];
    int   m_occ = 0;
    int   m_next = 0;
    logic [15:0] m_kvi = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Model: an entry issues at max(accept+2, earliest slot); a strobe pushes the next
    // slot out by the issue gap, a drop by one cycle.
    always @(negedge clk) begin : model
        logic e_enq, e_deq, e_ef, e_ed, e_rdy;
        int   pops, dlt;
        if (!rst_n) begin
            chk("rst_ready", if0.req_ready, 0);
            chk("rst_enq", if0.pq_enq, 0);
            chk("rst_deq", if0.pq_deq, 0);
            chk("rst_kvi", if0.pq_kvi, 0);
            chk("rst_occ", occ0, 0);
            chk("rst_fcount", fc0, 0);
            chk("rst_errs", {ef0, ed0}, 0);
            mq.delete();
            m_occ = 0;
            m_next = 0;
            m_kvi = '0;
        end else begin
            e_enq = 0; e_deq = 0; e_ef = 0; e_ed = 0; pops = 0; dlt = 0;
            if (mq.size() > 0 && mq[0].acc + 2 <= cyc && m_next <= cyc) begin
                if (mq[0].op == 1'b0) begin
                    if (mq.size() >= 2 && mq[1].op == 1'b1 && mq[1].acc + 2 <= cyc && m_occ >= 1) begin
                        e_enq = 1; e_deq = 1; pops = 2; m_kvi = mq[0].kv;
                    end else if (m_occ < CAP) begin
                        e_enq = 1; pops = 1; dlt = 1; m_kvi = mq[0].kv;
                    end else begin
                        e_ef = 1; pops = 1;
                    end
                end else if (m_occ >= 1) begin
                    e_deq = 1; pops = 1; dlt = -1;
                end else begin
                    e_ed = 1; pops = 1;
                end
                m_next = (e_enq || e_deq) ? cyc + GAPC : cyc + 1;
            end
            e_rdy = (mq.size() < DEPTH);
            chk("ready", if0.req_ready, e_rdy);
            chk("fifo_count", fc0, mq.size());
            chk("occ", occ0, m_occ);
            chk("pq_enq", if0.pq_enq, e_enq);
            chk("pq_deq", if0.pq_deq, e_deq);
            chk("pq_kvi", if0.pq_kvi, m_kvi);
            chk("err_enq_full", ef0, e_ef);
            chk("err_deq_empty", ed0, e_ed);
            if (if0.pq_enq || if0.pq_deq || ef0 || ed0)
                log0.push_back('{cyc, if0.pq_enq, if0.pq_deq, ef0, ed0, if0.pq_kvi, occ0});
            repeat (pops) void'(mq.pop_front());
            m_occ += dlt;
            if (req_valid && e_rdy)
                mq.push_back('{req_op, req_kv, cyc});
            if (fc0 == 4'd8 && !if0.req_ready)
                saw_full = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst_n && (if1.pq_enq || if1.pq_deq || ef1 || ed1))
            log1.push_back('{cyc, if1.pq_enq, if1.pq_deq, ef1, ed1, if1.pq_kvi, occ1});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        req_valid = 1'b0;
        tick(n);
        rst_n = 1'b1;
    endtask

    task automatic push(input logic op, input logic [15:0] kv, output int acc);
        int n;
        n = 0;
        acc = -1;
        req_valid = 1'b1;
        req_op = op;
        req_kv = kv;
        forever begin
            @(negedge clk);
            if (if0.req_ready === 1'b1) begin
                acc = cyc;
                break;
            end
            n++;
            if (n > 100) begin
                checks++;
                errors++;
                $display("FAIL push_wait: req_ready never rose, got 0 expected 1");
                break;
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    initial begin : stim
        int t, a, n_enq, n_ef, last_key, w;
        logic [7:0] k;

        // T1: reset with request pending
        req_valid = 1'b1;
        req_kv = 16'h0101;
        tick(3);
        @(negedge clk);
        chk("t1_ready_in_reset", if0.req_ready, 0);
        chk("t1_occ_in_reset", occ0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("t1_ready_after", if0.req_ready, 1);
        tick(1);

        // T2: spacing of back-to-back enqs
        log0.delete(); log1.delete();
        push(1'b0, {8'd13, 8'd11}, t);
        push(1'b0, {8'd12, 8'd15}, a);
        push(1'b0, {8'd10, 8'd15}, a);
        tick(14);
        chk("t2_nstrobes", log0.size(), 3);
        if (log0.size() == 3) begin
            chk("t2_c0", log0[0].c, t + 2);
            chk("t2_c1", log0[1].c, t + 6);
            chk("t2_c2", log0[2].c, t + 10);
            chk("t2_kv0", log0[0].kv, 16'h0D0B);
            chk("t2_kv1", log0[1].kv, 16'h0C0F);
            chk("t2_kv2", log0[2].kv, 16'h0A0F);
        end
        @(negedge clk);
        chk("t2_occ", occ0, 3);

        // T3: fill the PQ, 16th enq is dropped
        do_reset(2);
        log0.delete();
        for (int i = 1; i <= 16; i++) begin
            k = 8'(i);
            push(1'b0, {k, k}, a);
        end
        tick(50);
        n_enq = 0; n_ef = 0; last_key = 0;
        foreach (log0[i]) begin
            if (log0[i].enq) begin
                n_enq++;
                last_key = int'(log0[i].kv[15:8]);
            end
            if (log0[i].ef) begin
                n_ef++;
                chk("t3_occ_at_drop", log0[i].occ, 15);
            end
        end
        chk("t3_n_enq", n_enq, 15);
        chk("t3_n_err", n_ef, 1);
        chk("t3_last_key", last_key, 15);
        @(negedge clk);
        chk("t3_occ", occ0, 15);

        // T4: deq on empty PQ, then enq right behind it
        do_reset(2);
        log0.delete();
        push(1'b1, 16'h0000, t);
        push(1'b0, {8'd3, 8'd3}, a);
        tick(10);
        chk("t4_nev", log0.size(), 2);
        if (log0.size() == 2) begin
            chk("t4_err_cyc", log0[0].c, t + 2);
            chk("t4_err_kind", {log0[0].enq, log0[0].deq, log0[0].ef, log0[0].ed}, 4'b0001);
            chk("t4_err_occ", log0[0].occ, 0);
            chk("t4_enq_cyc", log0[1].c, t + 3);
            chk("t4_enq_kv", log0[1].kv, 16'h0303);
        end
        @(negedge clk);
        chk("t4_occ", occ0, 1);

        // T5: enq,deq pair at occ=2, merged vs. unmerged
        do_reset(2);
        log0.delete(); log1.delete();
        push(1'b0, {8'd1, 8'd1}, t);
        push(1'b0, {8'd2, 8'd2}, a);
        push(1'b0, {8'd9, 8'd9}, a);
        push(1'b1, 16'h0000, a);
        tick(25);
        chk("t5_m_nev", log0.size(), 3);
        if (log0.size() == 3) begin
            chk("t5_m_cyc", log0[2].c, t + 10);
            chk("t5_m_both", {log0[2].enq, log0[2].deq}, 2'b11);
            chk("t5_m_kv", log0[2].kv, 16'h0909);
            chk("t5_m_occ_before", log0[2].occ, 2);
        end
        chk("t5_u_nev", log1.size(), 4);
        if (log1.size() == 4) begin
            chk("t5_u_enq_cyc", log1[2].c, t + 10);
            chk("t5_u_enq_kind", {log1[2].enq, log1[2].deq}, 2'b10);
            chk("t5_u_enq_kv", log1[2].kv, 16'h0909);
            chk("t5_u_deq_cyc", log1[3].c, t + 14);
            chk("t5_u_deq_kind", {log1[3].enq, log1[3].deq}, 2'b01);
        end
        @(negedge clk);
        chk("t5_m_occ", occ0, 2);
        chk("t5_u_occ", occ1, 2);

        // T6: backpressure, then reset during a gap
        do_reset(2);
        saw_full = 1'b0;
        for (int i = 20; i < 32; i++) begin
            k = 8'(i);
            push(1'b0, {k, k}, a);
        end
        chk("t6_saw_full", saw_full, 1);
        w = 0;
        forever begin
            @(negedge clk);
            if (if0.pq_enq === 1'b1) break;
            w++;
            if (w > 20) begin
                checks++;
                errors++;
                $display("FAIL t6_strobe_wait: no strobe seen, got 0 expected 1");
                break;
            end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_fcount_in_reset", fc0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        log0.delete();
        @(negedge clk);
        chk("t6_fcount_after", fc0, 0);
        chk("t6_occ_after", occ0, 0);
        tick(10);
        chk("t6_no_strobe", log0.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
